// File: rtl/osc_pulse_if.sv
// Control and sample bundle between the synth controller and one osc_pulse voice.
interface osc_pulse_if #(
    parameter int FREQ_W = 12,
    parameter int OUT_W  = 16,
    parameter int DUTY_W = 8
);
    logic              en;
    logic [FREQ_W-1:0] freq;
    logic              freq_load;
    logic [DUTY_W-1:0] duty;
    logic [OUT_W-2:0]  amp;
    logic [OUT_W-1:0]  sig;
    logic              busy;
    logic              period_tick;

    modport master (
        output en, freq, freq_load, duty, amp,
        input  sig, busy, period_tick
    );

    modport slave (
        input  en, freq, freq_load, duty, amp,
        output sig, busy, period_tick
    );
endinterface

// File: rtl/osc_pulse.sv
// Pulse/square oscillator with runtime frequency, duty, amplitude and enable.
// A frequency request runs through an iterative restoring divider (CLK_HZ/freq).
// New period, mute and duty values are committed only at a period wrap (or
// at once while disabled), so the running waveform never glitches.
module osc_pulse #(
    parameter int CLK_HZ     = 1000000,
    parameter int FREQ_W     = 12,
    parameter int OUT_W      = 16,
    parameter int DUTY_W     = 8,
    parameter int PER_W      = 32,
    parameter int RESET_FREQ = 440
) (
    input  logic       clk,
    input  logic       rst,
    osc_pulse_if.slave bus
);
    localparam int CNT_W = $clog2(PER_W);
    localparam logic [PER_W-1:0] DIVIDEND  = PER_W'(CLK_HZ);
    localparam logic [PER_W-1:0] RESET_PER = PER_W'(CLK_HZ / RESET_FREQ);
    // High time of the reset period at the 50% duty code 2^(DUTY_W-1).
    localparam logic [PER_W-1:0] RESET_HI  =
        PER_W'((longint'(CLK_HZ / RESET_FREQ) << (DUTY_W - 1)) >> DUTY_W);

    typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_e;

    // Divider
    div_state_e        state, state_next;
    logic [FREQ_W-1:0] div_freq;
    logic [PER_W-1:0]  rem;
    logic [PER_W-1:0]  quo;
    logic [CNT_W-1:0]  bit_cnt;
    logic [PER_W:0]    rem_sh;
    logic [PER_W:0]    divisor;
    logic              rem_ge;
    logic              done_fire;
    logic              done_mute;
    logic [PER_W-1:0]  done_per;

    // Period counter and committed waveform settings
    logic [PER_W-1:0]  per;
    logic [PER_W-1:0]  per_next;
    logic [PER_W-1:0]  hi;
    logic [PER_W-1:0]  cnt;
    logic              mute;
    logic              mute_next;
    logic              pending;
    logic [PER_W-1:0]  per_base;
    logic              mute_base;
    logic [PER_W-1:0]  per_eff;
    logic              mute_eff;
    logic [PER_W+DUTY_W-1:0] prod;
    logic [PER_W-1:0]  hi_raw;
    logic [PER_W-1:0]  hi_eff;
    logic              wrap;
    logic              commit;
    logic              tick_q;
    logic [OUT_W-1:0]  sig_q;
    logic [OUT_W-1:0]  amp_ext;

    // ------------------------------------------------------------------
    // Divider: one restoring step per cycle, quotient shifts in from the LSB
    // while the dividend shifts out of the MSB of the same register.
    // ------------------------------------------------------------------
    assign rem_sh  = {rem, quo[PER_W-1]};
    assign divisor = {{(PER_W + 1 - FREQ_W){1'b0}}, div_freq};
    assign rem_ge  = (rem_sh >= divisor);

    // A load in DONE supersedes the finished result, so the store is skipped.
    assign done_fire = (state == DONE) && !bus.freq_load;
    assign done_mute = (div_freq == '0);

    // The quotient of a PER_W-bit dividend always fits PER_W bits, so only the
    // lower clamp is needed; freq=0 keeps whichever period is already queued.
    assign per_base  = pending ? per_next  : per;
    assign mute_base = pending ? mute_next : mute;
    assign done_per  = done_mute ? per_base
                     : ((quo < PER_W'(2)) ? PER_W'(2) : quo);

    // Divider state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // in this edge samples the values from before the edge.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Divider next-state: a load in any state restarts; freq=0 skips the divide.
    always_comb begin
        // NOTE: the default is assigned first so every path drives state_next
        // and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            DIV:     if (bit_cnt == CNT_W'(PER_W - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.freq_load) state_next = (bus.freq == '0) ? DONE : DIV;
    end

    // Divider datapath: latch the request on load, iterate while in DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_freq <= '0;
            rem      <= '0;
            quo      <= '0;
            bit_cnt  <= '0;
        end else if (bus.freq_load) begin
            div_freq <= bus.freq;
            rem      <= '0;
            quo      <= DIVIDEND;
            bit_cnt  <= '0;
        end else if (state == DIV) begin
            rem      <= rem_ge ? PER_W'(rem_sh - divisor) : PER_W'(rem_sh);
            quo      <= {quo[PER_W-2:0], rem_ge};
            bit_cnt  <= bit_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Period counter and commit point
    // ------------------------------------------------------------------
    assign wrap   = bus.en && (cnt == per - 1'b1);
    assign commit = !bus.en || wrap;

    // A result finishing on the commit edge is used straight away.
    assign per_eff  = done_fire ? done_per  : per_base;
    assign mute_eff = done_fire ? done_mute : mute_base;

    assign prod   = {{DUTY_W{1'b0}}, per_eff} * {{PER_W{1'b0}}, bus.duty};
    assign hi_raw = PER_W'(prod >> DUTY_W);

    // Keep at least one high and one low cycle in every period.
    always_comb begin
        hi_eff = hi_raw;
        if (hi_raw == '0)          hi_eff = PER_W'(1);
        else if (hi_raw >= per_eff) hi_eff = per_eff - 1'b1;
    end

    // Counter, wrap tick and commit of queued period/mute/duty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            tick_q    <= 1'b0;
            per       <= RESET_PER;
            hi        <= RESET_HI;
            mute      <= 1'b0;
            per_next  <= RESET_PER;
            mute_next <= 1'b0;
            pending   <= 1'b0;
        end else begin
            tick_q <= wrap;
            if (!bus.en || wrap) cnt <= '0;
            else                 cnt <= cnt + 1'b1;

            if (commit) begin
                per  <= per_eff;
                mute <= mute_eff;
                hi   <= hi_eff;
            end

            if (done_fire) begin
                per_next  <= done_per;
                mute_next <= done_mute;
            end

            if (done_fire && !commit) pending <= 1'b1;
            else if (commit)          pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output sample: high phase +amp, low phase bitwise complement.
    // ------------------------------------------------------------------
    assign amp_ext = {1'b0, bus.amp};

    // Registered sample reflecting the counter one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   sig_q <= '0;
        else if (!bus.en || mute)  sig_q <= '0;
        else if (cnt < hi)         sig_q <= amp_ext;
        else                       sig_q <= ~amp_ext;
    end

    assign bus.sig         = sig_q;
    assign bus.busy        = (state == DIV);
    assign bus.period_tick = tick_q;
endmodule

// File: tb/tb_osc_pulse.sv
// Directed bench for osc_pulse: table of frequency/duty/amplitude vectors
// measured over one full period each, plus hand-written multi-cycle sequences.
module tb_osc_pulse;
    localparam int FREQ_W = 12;
    localparam int OUT_W  = 16;
    localparam int DUTY_W = 8;

    typedef struct {
        logic [FREQ_W-1:0] freq;
        logic [DUTY_W-1:0] duty;
        logic [OUT_W-2:0]  amp;
        int                exp_per;
        int                exp_hi;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    osc_pulse_if #(.FREQ_W(FREQ_W), .OUT_W(OUT_W), .DUTY_W(DUTY_W)) bus ();

    osc_pulse #(
        .CLK_HZ    (1000000),
        .FREQ_W    (FREQ_W),
        .OUT_W     (OUT_W),
        .DUTY_W    (DUTY_W),
        .PER_W     (32),
        .RESET_FREQ(440)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven at the negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_load(input logic [FREQ_W-1:0] f);
        bus.freq      = f;
        bus.freq_load = 1'b1;
        step();
        bus.freq_load = 1'b0;
    endtask

    task automatic wait_busy_low(output int busy_cycles);
        busy_cycles = 0;
        while (bus.busy === 1'b1 && busy_cycles < 500) begin
            busy_cycles++;
            step();
        end
        if (bus.busy !== 1'b0) check("busy_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.period_tick !== 1'b1 && n < 5000);
        if (bus.period_tick !== 1'b1) check("tick_timeout", {31'd0, bus.period_tick}, 32'd1);
    endtask

    // Count cycles up to and including the next period_tick, classifying sig.
    task automatic measure(input logic [OUT_W-1:0] hv, input logic [OUT_W-1:0] lv,
                           output int per, output int hn, output int ln, output int on);
        per = 0; hn = 0; ln = 0; on = 0;
        do begin
            step();
            per++;
            if (bus.sig === hv)      hn++;
            else if (bus.sig === lv) ln++;
            else                     on++;
        end while (bus.period_tick !== 1'b1 && per < 5000);
        if (bus.period_tick !== 1'b1) check("measure_timeout", {31'd0, bus.period_tick}, 32'd1);
    endtask

    task automatic check_period(input string name, input logic [OUT_W-1:0] hv, input logic [OUT_W-1:0] lv,
                                input int exp_per, input int exp_hi);
        int per, hn, ln, on;
        measure(hv, lv, per, hn, ln, on);
        check({name, "_period"}, per, exp_per);
        check({name, "_high"},   hn,  exp_hi);
        check({name, "_low"},    ln,  exp_per - exp_hi);
        check({name, "_other"},  on,  0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   bc;
        int   bc2;
        int   per;
        int   busy_n;
        int   hn;
        int   nz;
        int   ticks;

        vecs[0] = '{12'd1000, 8'd128, 15'h0FFF, 1000, 500};
        vecs[1] = '{12'd1000, 8'd64,  15'h1234, 1000, 250};
        vecs[2] = '{12'd1000, 8'd0,   15'h7FFF, 1000, 1};
        vecs[3] = '{12'd1000, 8'd255, 15'h0001, 1000, 996};
        vecs[4] = '{12'd2000, 8'd128, 15'h0400, 500,  250};
        vecs[5] = '{12'd4000, 8'd128, 15'h2AAA, 250,  125};
        vecs[6] = '{12'd4095, 8'd200, 15'h0FFF, 244,  190};

        // Reset state and the default 440 Hz square.
        rst           = 1'b1;
        bus.en        = 1'b1;
        bus.freq      = '0;
        bus.freq_load = 1'b0;
        bus.duty      = 8'd128;
        bus.amp       = 15'h0FFF;
        repeat (3) @(negedge clk);
        check("rst_sig",  {16'd0, bus.sig}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_tick", {31'd0, bus.period_tick}, 32'd0);
        rst = 1'b0;
        check_period("t1_first",  16'h0FFF, 16'hF000, 2272, 1136);
        check_period("t1_second", 16'h0FFF, 16'hF000, 2272, 1136);

        // Load 1000 Hz mid-period: the running 2272 period finishes untouched.
        per = 0; busy_n = 0; hn = 0;
        do begin
            if (per == 100) begin
                bus.freq      = 12'd1000;
                bus.freq_load = 1'b1;
            end else begin
                bus.freq_load = 1'b0;
            end
            step();
            per++;
            if (bus.busy === 1'b1) busy_n++;
            if (bus.sig === 16'h0FFF) hn++;
        end while (bus.period_tick !== 1'b1 && per < 5000);
        bus.freq_load = 1'b0;
        check("t2_old_period", per, 2272);
        check("t2_old_high",   hn,  1136);
        check("t2_busy_len",   busy_n, 32);
        check_period("t2_new", 16'h0FFF, 16'hF000, 1000, 500);

        // Table-driven frequency/duty/amplitude vectors.
        for (int i = 0; i < 7; i++) begin
            bus.duty = vecs[i].duty;
            bus.amp  = vecs[i].amp;
            pulse_load(vecs[i].freq);
            wait_busy_low(bc);
            check($sformatf("vec%0d_busy", i), bc, 32);
            wait_tick();
            check_period($sformatf("vec%0d", i), {1'b0, vecs[i].amp}, ~{1'b0, vecs[i].amp},
                         vecs[i].exp_per, vecs[i].exp_hi);
        end

        // Second load 10 cycles after the first: last load wins.
        bus.duty = 8'd128;
        bus.amp  = 15'h0FFF;
        repeat (50) step();
        pulse_load(12'd1000);
        bc = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.busy === 1'b1) bc++;
            step();
        end
        if (bus.busy === 1'b1) bc++;
        pulse_load(12'd500);
        wait_busy_low(bc2);
        check("t4_busy_len", bc + bc2, 42);
        wait_tick();
        check_period("t4_first",  16'h0FFF, 16'hF000, 2000, 1000);
        check_period("t4_second", 16'h0FFF, 16'hF000, 2000, 1000);

        // freq=0 mutes from the next wrap; 440 Hz resumes at a wrap.
        pulse_load(12'd0);
        wait_busy_low(bc);
        check("t5_zero_busy", bc, 0);
        wait_tick();
        check_period("t5_mute", 16'h0000, 16'h0000, 2000, 2000);
        pulse_load(12'd440);
        wait_busy_low(bc);
        check("t5_resume_busy", bc, 32);
        wait_tick();
        check_period("t5_resume", 16'h0FFF, 16'hF000, 2272, 1136);

        // Enable low: silent next cycle, no ticks, duty committed immediately.
        bus.en   = 1'b0;
        bus.duty = 8'd64;
        step();
        check("t5_en_off_sig", {16'd0, bus.sig}, 32'd0);
        ticks = 0; nz = 0;
        for (int i = 0; i < 2500; i++) begin
            step();
            if (bus.period_tick === 1'b1) ticks++;
            if (bus.sig !== 16'h0000) nz++;
        end
        check("t5_en_off_ticks",   ticks, 0);
        check("t5_en_off_nonzero", nz, 0);
        bus.en = 1'b1;
        check_period("t5_en_on", 16'h0FFF, 16'hF000, 2272, 568);

        // Reset during a division and a high phase.
        bus.duty = 8'd128;
        repeat (5) step();
        pulse_load(12'd1000);
        repeat (10) step();
        check("t6_pre_busy", {31'd0, bus.busy}, 32'd1);
        check("t6_pre_sig",  {16'd0, bus.sig}, 32'h0FFF);
        rst = 1'b1;
        #1;
        check("t6_rst_sig",  {16'd0, bus.sig}, 32'd0);
        check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("t6_rst_tick", {31'd0, bus.period_tick}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_period("t6_first",  16'h0FFF, 16'hF000, 2272, 1136);
        check_period("t6_second", 16'h0FFF, 16'hF000, 2272, 1136);
        check("t6_end_busy", {31'd0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
